// File: rtl/wdg_rst_ctrl.sv
// Watchdog reset controller: stretches reset requests, records causes.
// Optional reset counter in RSR[23:16] built when WDG_RST_CNT_EN is defined.
module wdg_rst_ctrl #(
  parameter int HOLD_RST  = 16,
  parameter int BLANK_CYC = 2
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  input  logic        wdg_rst,
  input  logic        wdg_int,
  output logic        sys_rst_n,
  output logic        irq
);

  typedef enum logic [1:0] {
    ASSERT,
    BLANK,
    IDLE
  } state_t;

  localparam logic [7:0] HOLD_INIT = 8'(HOLD_RST);
  localparam logic [7:0] BLANK_M1  = 8'(BLANK_CYC - 1);

  state_t     state;
  logic [7:0] cnt;
  logic [7:0] hold;
  logic       ie;
  logic       wdgrstf;
  logic       swrstf;
  logic       porf;
  logic [7:0] rstcnt;

  logic       wr;
  logic       rd;
  logic       sel_rcr;
  logic       sel_rsr;
  logic       swrst_req;
  logic       accept;
  logic [7:0] hold_wr;
  logic [31:0] rcr_val;
  logic [31:0] rsr_val;
  logic       unused_bits;

  assign wr        = psel & ~penable & pwrite;
  assign rd        = psel & ~penable & ~pwrite;
  assign sel_rcr   = (paddr == 32'h0000_0000);
  assign sel_rsr   = (paddr == 32'h0000_0004);
  assign swrst_req = wr & sel_rcr & pwdata[0];
  assign accept    = (state == IDLE) & (wdg_rst | swrst_req);
  assign hold_wr   = (pwdata[15:8] == 8'd0) ? 8'd1 : pwdata[15:8];
  assign irq       = wdg_int & ie;

  assign rcr_val = {16'd0, hold, 6'd0, ie, 1'b0};
  assign rsr_val = {8'd0, rstcnt, 13'd0, porf, swrstf, wdgrstf};

  assign unused_bits = ^{pwdata[31:16], pwdata[7:3]};

  // A shortened HOLD applies at once: >= lets an overrun counter exit.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= ASSERT;
      cnt       <= 8'd0;
      sys_rst_n <= 1'b0;
    end else begin
      unique case (state)
        ASSERT: begin
          if (cnt >= hold - 8'd1) begin
            state     <= BLANK;
            cnt       <= 8'd0;
            sys_rst_n <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        BLANK: begin
          if (cnt >= BLANK_M1) begin
            state <= IDLE;
            cnt   <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        IDLE: begin
          if (accept) begin
            state     <= ASSERT;
            cnt       <= 8'd0;
            sys_rst_n <= 1'b0;
          end
        end
        default: begin
          state     <= ASSERT;
          cnt       <= 8'd0;
          sys_rst_n <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      ie      <= 1'b0;
      hold    <= HOLD_INIT;
      wdgrstf <= 1'b0;
      swrstf  <= 1'b0;
      porf    <= 1'b1;
    end else begin
      if (wr && sel_rcr) begin
        ie   <= pwdata[1];
        hold <= hold_wr;
      end
      if (wr && sel_rsr) begin
        wdgrstf <= (wdgrstf & ~pwdata[0]) | (accept & wdg_rst);
        swrstf  <= (swrstf & ~pwdata[1]) | (accept & swrst_req);
        porf    <= porf & ~pwdata[2];
      end else begin
        wdgrstf <= wdgrstf | (accept & wdg_rst);
        swrstf  <= swrstf | (accept & swrst_req);
      end
    end
  end

`ifdef WDG_RST_CNT_EN
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rstcnt <= 8'd0;
    end else if (accept) begin
      if (rstcnt != 8'hff) rstcnt <= rstcnt + 8'd1;
    end else if (wr && sel_rsr && pwdata[31]) begin
      rstcnt <= 8'd0;
    end
  end
`else
  assign rstcnt = 8'd0;
`endif

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      prdata <= 32'd0;
    end else if (rd) begin
      unique case (1'b1)
        sel_rcr: prdata <= rcr_val;
        sel_rsr: prdata <= rsr_val;
        default: prdata <= 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_wdg_rst_ctrl.sv
// Directed bench for wdg_rst_ctrl.
// Expected RSR counter fields follow WDG_RST_CNT_EN when defined.
module tb_wdg_rst_ctrl;

  logic        pclk;
  logic        presetn;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        wdg_rst;
  logic        wdg_int;
  logic        sys_rst_n;
  logic        irq;

  int checks = 0;
  int fails  = 0;

  wdg_rst_ctrl dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .wdg_rst   (wdg_rst),
    .wdg_int   (wdg_int),
    .sys_rst_n (sys_rst_n),
    .irq       (irq)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cntf(input int n);
`ifdef WDG_RST_CNT_EN
    return 32'(n) << 16;
`else
    return 32'd0;
`endif
  endfunction

  // setup phase with optional wdg_rst in the same cycle
  task automatic req(input logic sel, input logic [31:0] a,
                     input logic [31:0] d, input logic w);
    @(negedge pclk);
    psel    = sel;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = a;
    pwdata  = d;
    wdg_rst = w;
    @(posedge pclk);
    #1;
    penable = sel;
    wdg_rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pclk);
      #1;
      psel    = 1'b0;
      penable = 1'b0;
    end
  endtask

  task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
    req(1'b1, a, d, 1'b0);
    idle(1);
  endtask

  task automatic apb_rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge pclk);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = a;
    @(posedge pclk);
    #1;
    penable = 1'b1;
    @(negedge pclk);
    d = prdata;
    idle(1);
  endtask

  // edges until sys_rst_n is seen high, bounded
  task automatic measure(input string tag, input int exp);
    int n;
    n = 0;
    do begin
      @(posedge pclk);
      #1;
      psel    = 1'b0;
      penable = 1'b0;
      n++;
    end while (!sys_rst_n && n < 400);
    chk(tag, 32'(n), 32'(exp));
  endtask

  logic [31:0] rv;

  initial begin
    presetn = 1'b0;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 32'd0;
    pwdata  = 32'd0;
    wdg_rst = 1'b0;
    wdg_int = 1'b0;
    #23;
    chk("rst_sys", 32'(sys_rst_n), 32'd0);
    chk("rst_prdata", prdata, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);

    @(negedge pclk);
    presetn = 1'b1;
    measure("por_len", 16);
    idle(3);
    apb_rd(32'h4, rv);
    chk("por_rsr", rv, 32'h4);
    apb_rd(32'h0, rv);
    chk("por_rcr", rv, 32'h1000);

    apb_wr(32'h4, 32'h8000_0007);
    apb_wr(32'h0, 32'h0000_0400);
    apb_rd(32'h4, rv);
    chk("clr_rsr", rv, 32'h0);
    apb_rd(32'h0, rv);
    chk("hold4_rcr", rv, 32'h400);
    apb_rd(32'h8, rv);
    chk("unmapped_rd", rv, 32'h0);

    req(1'b0, 32'h0, 32'h0, 1'b1);
    chk("wdg_low", 32'(sys_rst_n), 32'd0);
    measure("wdg_len", 4);
    idle(3);
    apb_rd(32'h4, rv);
    chk("wdg_rsr", rv, 32'h1 | cntf(1));

    apb_wr(32'h4, 32'h8000_0007);
    req(1'b1, 32'h0, 32'h0000_0401, 1'b1);
    chk("both_low", 32'(sys_rst_n), 32'd0);
    measure("both_len", 4);
    wdg_rst = 1'b1;
    @(posedge pclk);
    #1;
    wdg_rst = 1'b0;
    chk("blank_ign", 32'(sys_rst_n), 32'd1);
    idle(3);
    apb_rd(32'h4, rv);
    chk("both_rsr", rv, 32'h3 | cntf(1));

    req(1'b1, 32'h4, 32'h0000_0001, 1'b1);
    measure("soc_len", 4);
    idle(3);
    apb_rd(32'h4, rv);
    chk("set_over_clr", rv, 32'h3 | cntf(2));

    apb_wr(32'h0, 32'h0000_0000);
    apb_rd(32'h0, rv);
    chk("hold0_rcr", rv, 32'h100);
    req(1'b1, 32'h0, 32'h0000_0001, 1'b0);
    chk("h1_low", 32'(sys_rst_n), 32'd0);
    measure("h1_len", 1);
    idle(3);

    @(negedge pclk);
    wdg_int = 1'b1;
    #1;
    chk("irq_ie0", 32'(irq), 32'd0);
    apb_wr(32'h0, 32'h0000_0102);
    chk("irq_ie1", 32'(irq), 32'd1);
    @(negedge pclk);
    wdg_int = 1'b0;
    #1;
    chk("irq_follow", 32'(irq), 32'd0);

    apb_wr(32'h0, 32'h0000_0800);
    req(1'b1, 32'h0, 32'h0000_0801, 1'b0);
    idle(4);
    req(1'b1, 32'h0, 32'h0000_0200, 1'b0);
    chk("shrink_low", 32'(sys_rst_n), 32'd0);
    measure("shrink_len", 1);
    idle(3);
    apb_rd(32'h4, rv);
    chk("shrink_rsr", rv, 32'h3 | cntf(4));

`ifdef WDG_RST_CNT_EN
    apb_wr(32'h0, 32'h0000_0100);
    for (int i = 0; i < 256; i++) begin
      req(1'b1, 32'h0, 32'h0000_0101, 1'b0);
      idle(4);
    end
    apb_rd(32'h4, rv);
    chk("cnt_sat", (rv >> 16) & 32'hff, 32'hff);
    apb_wr(32'h4, 32'h8000_0000);
    apb_rd(32'h4, rv);
    chk("cnt_clr", (rv >> 16) & 32'hff, 32'h0);
`endif

    apb_wr(32'h0, 32'h0000_0803);
    apb_rd(32'h0, rv);
    idle(2);
    @(negedge pclk);
    presetn = 1'b0;
    #1;
    chk("mid_sys", 32'(sys_rst_n), 32'd0);
    chk("mid_prdata", prdata, 32'd0);
    @(negedge pclk);
    presetn = 1'b1;
    measure("mid_len", 16);
    idle(3);
    apb_rd(32'h0, rv);
    chk("mid_rcr", rv, 32'h1000);
    apb_rd(32'h4, rv);
    chk("mid_rsr", rv, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
